// File: rtl/cc_cond_unit.sv
// Y86 execute-stage condition codes, jXX/cmovXX condition evaluation and the E/M pipeline register.
// CC and E/M state update one cycle after Execute; m_stall holds E/M and suppresses the CC update, m_bubble clears E/M.
module cc_cond_unit #(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e_valid,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ovf,
    input  logic             cc_block,
    input  logic             m_stall,
    input  logic             m_bubble,
    output logic [2:0]       cc,
    output logic             e_cnd,
    output logic             cond_err,
    output logic             M_valid,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE
);

    localparam logic [3:0] ICODE_CMOV = 4'd2;
    localparam logic [3:0] ICODE_OPQ  = 4'd6;
    localparam logic [3:0] ICODE_JXX  = 4'd7;

    logic [2:0]       cc_q, cc_d;
    logic             m_valid_q, m_valid_d;
    logic             m_cnd_q, m_cnd_d;
    logic [WIDTH-1:0] m_vale_q, m_vale_d;

    logic zf, sf, of, lt;
    logic uses_cnd, cnd_raw, set_cc;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];
    assign lt = sf ^ of;

    // Condition comes only from the registered flags, never from this cycle's ALU result.
    always_comb begin
        uses_cnd = e_valid & ((e_icode == ICODE_CMOV) | (e_icode == ICODE_JXX));
        cnd_raw  = 1'b0;
        case (e_ifun)
            4'd0:    cnd_raw = 1'b1;
            4'd1:    cnd_raw = lt | zf;
            4'd2:    cnd_raw = lt;
            4'd3:    cnd_raw = zf;
            4'd4:    cnd_raw = ~zf;
            4'd5:    cnd_raw = ~lt;
            4'd6:    cnd_raw = ~lt & ~zf;
            default: cnd_raw = 1'b0;
        endcase
        e_cnd    = uses_cnd & cnd_raw;
        cond_err = uses_cnd & (e_ifun > 4'd6);
    end

    always_comb begin
        set_cc = e_valid & (e_icode == ICODE_OPQ) & ~cc_block & ~m_stall;
        cc_d   = cc_q;
        if (set_cc) begin
            cc_d = {(alu_out == '0), alu_out[WIDTH-1], alu_ovf};
        end
    end

    // Stall takes priority over bubble.
    always_comb begin
        m_valid_d = m_valid_q;
        m_cnd_d   = m_cnd_q;
        m_vale_d  = m_vale_q;
        if (!m_stall) begin
            if (m_bubble) begin
                m_valid_d = 1'b0;
                m_cnd_d   = 1'b0;
                m_vale_d  = '0;
            end else begin
                m_valid_d = e_valid;
                m_cnd_d   = e_cnd;
                m_vale_d  = alu_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q      <= CC_RESET;
            m_valid_q <= 1'b0;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
        end else begin
            cc_q      <= cc_d;
            m_valid_q <= m_valid_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
        end
    end

    assign cc      = cc_q;
    assign M_valid = m_valid_q;
    assign M_cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed and random checks of cc_cond_unit against a flag/condition reference model.
module tb_cc_cond_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        e_valid;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [63:0] alu_out;
    logic        alu_ovf;
    logic        cc_block;
    logic        m_stall;
    logic        m_bubble;
    logic [2:0]  cc;
    logic        e_cnd;
    logic        cond_err;
    logic        M_valid;
    logic        M_cnd;
    logic [63:0] M_valE;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: flags as ZF/SF/OF and the E/M contents.
    logic [2:0]  mcc;
    logic        mvalid, mcnd;
    logic [63:0] mvale;

    cc_cond_unit #(.WIDTH(64), .CC_RESET(3'b100)) dut (
        .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
        .alu_out(alu_out), .alu_ovf(alu_ovf), .cc_block(cc_block), .m_stall(m_stall),
        .m_bubble(m_bubble), .cc(cc), .e_cnd(e_cnd), .cond_err(cond_err),
        .M_valid(M_valid), .M_cnd(M_cnd), .M_valE(M_valE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Y86 branch semantics: "less" means the true (unwrapped) result was negative.
    function automatic logic ref_cond(input logic [3:0] ifun, input logic [2:0] f);
        logic zero, less;
        zero = f[2];
        less = f[1] != f[0];
        case (ifun)
            4'd0: return 1'b1;
            4'd1: return less || zero;
            4'd2: return less;
            4'd3: return zero;
            4'd4: return !zero;
            4'd5: return !less;
            4'd6: return !less && !zero;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_cond();
        return e_valid && (e_icode == 4'd2 || e_icode == 4'd7);
    endfunction

    function automatic logic exp_cnd();
        return uses_cond() && ref_cond(e_ifun, mcc);
    endfunction

    function automatic logic exp_err();
        return uses_cond() && (e_ifun > 4'd6);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".cc"}, 64'(cc), 64'(mcc));
        chk({tag, ".e_cnd"}, 64'(e_cnd), 64'(exp_cnd()));
        chk({tag, ".cond_err"}, 64'(cond_err), 64'(exp_err()));
        chk({tag, ".M_valid"}, 64'(M_valid), 64'(mvalid));
        chk({tag, ".M_cnd"}, 64'(M_cnd), 64'(mcnd));
        chk({tag, ".M_valE"}, M_valE, mvale);
    endtask

    task automatic model_reset();
        mcc = 3'b100; mvalid = 1'b0; mcnd = 1'b0; mvale = 64'd0;
    endtask

    // Predict the edge from the inputs held across it, then advance to just after the edge.
    task automatic tick();
        logic [2:0]  ncc;
        logic        nv, nc;
        logic [63:0] nve;
        ncc = mcc; nv = mvalid; nc = mcnd; nve = mvale;
        if (e_valid && e_icode == 4'd6 && !cc_block && !m_stall)
            ncc = {alu_out == 64'd0, alu_out[63], alu_ovf};
        if (!m_stall) begin
            if (m_bubble) begin
                nv = 1'b0; nc = 1'b0; nve = 64'd0;
            end else begin
                nv = e_valid; nc = exp_cnd(); nve = alu_out;
            end
        end
        @(posedge clk);
        #1;
        mcc = ncc; mvalid = nv; mcnd = nc; mvale = nve;
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic ov);
        e_valid = v; e_icode = ic; e_ifun = fn; alu_out = a; alu_ovf = ov;
    endtask

    task automatic opq(input logic [63:0] a, input logic ov);
        drive(1'b1, 4'd6, 4'd0, a, ov);
        tick();
    endtask

    initial begin
        logic [2:0]  f;
        logic [63:0] a;
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 64'd0, 1'b0);
        cc_block = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset_cc_const", 64'(cc), 64'h4);
        rst_n = 1'b1;

        drive(1'b1, 4'd7, 4'd3, 64'd0, 1'b0);
        #1;
        chk("post_reset_je", 64'(e_cnd), 64'd1);

        opq(64'd0, 1'b0);
        chk("opq_zero_cc", 64'(cc), 64'h4);
        opq(64'h8000_0000_0000_0000, 1'b1);
        chk("opq_neg_ovf_cc", 64'(cc), 64'h3);
        check_all("opq_neg_ovf");

        drive(1'b1, 4'd7, 4'd2, 64'd0, 1'b0); #1; chk("jl_after_ovf", 64'(e_cnd), 64'd0);
        drive(1'b1, 4'd7, 4'd1, 64'd0, 1'b0); #1; chk("jle_after_ovf", 64'(e_cnd), 64'd0);
        drive(1'b1, 4'd7, 4'd4, 64'd0, 1'b0); #1; chk("jne_after_ovf", 64'(e_cnd), 64'd1);

        // Every flag combination reachable from an OPq (ZF=1 forces SF=0).
        for (int k = 0; k < 6; k++) begin
            f = (k < 4) ? 3'(k) : {1'b1, 1'b0, k[0]};
            a = f[2] ? 64'd0 : (f[1] ? 64'h8000_0000_0000_0001 : 64'd7);
            opq(a, f[0]);
            chk("sweep_cc", 64'(cc), 64'(f));
            for (int fn = 0; fn < 7; fn++) begin
                drive(1'b1, 4'd7, 4'(fn), 64'd0, 1'b0);
                #1;
                chk("sweep_cnd", 64'(e_cnd), 64'(ref_cond(4'(fn), f)));
                chk("sweep_err", 64'(cond_err), 64'd0);
            end
        end
        drive(1'b1, 4'd2, 4'd9, 64'd0, 1'b0);
        #1;
        chk("cmov_bad_cnd", 64'(e_cnd), 64'd0);
        chk("cmov_bad_err", 64'(cond_err), 64'd1);

        opq(64'h8000_0000_0000_0000, 1'b0);
        f = mcc;
        cc_block = 1'b1;
        opq(64'd5, 1'b0);
        cc_block = 1'b0;
        chk("block_cc", 64'(cc), 64'(f));
        chk("block_valE", M_valE, 64'd5);

        drive(1'b1, 4'd7, 4'd0, 64'd99, 1'b0);
        tick();
        m_stall = 1'b1; m_bubble = 1'b1;
        drive(1'b1, 4'd6, 4'd0, 64'd1234, 1'b0);
        tick(); tick();
        chk("stall_bubble_valE", M_valE, 64'd99);
        chk("stall_bubble_cnd", 64'(M_cnd), 64'd1);
        check_all("stall_bubble");
        m_stall = 1'b0;
        tick();
        chk("bubble_valid", 64'(M_valid), 64'd0);
        chk("bubble_cnd", 64'(M_cnd), 64'd0);
        m_bubble = 1'b0;

        opq(64'h8000_0000_0000_0000, 1'b1);
        m_stall = 1'b1;
        drive(1'b1, 4'd6, 4'd1, 64'd0, 1'b0);
        tick();
        chk("stall_opq_hold", 64'(cc), 64'h3);
        m_stall = 1'b0;
        tick();
        chk("stall_opq_release", 64'(cc), 64'h4);

        opq(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        drive(1'b0, 4'd6, 4'd0, 64'd0, 1'b0);
        tick();
        chk("exec_bubble_cc", 64'(cc), 64'h2);
        chk("exec_bubble_valid", 64'(M_valid), 64'd0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: e_icode = 4'd2;
                1: e_icode = 4'd6;
                2: e_icode = 4'd7;
                default: e_icode = 4'($urandom_range(0, 15));
            endcase
            e_valid  = ($urandom_range(0, 7) != 0);
            e_ifun   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            alu_out  = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom, $urandom};
            alu_ovf  = 1'($urandom_range(0, 1));
            cc_block = ($urandom_range(0, 7) == 0);
            m_stall  = ($urandom_range(0, 7) == 0);
            m_bubble = ($urandom_range(0, 7) == 0);
            #1;
            check_all("rand_pre");
            tick();
            check_all("rand_post");
        end

        cc_block = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
        opq(64'd3, 1'b1);
        drive(1'b1, 4'd7, 4'd5, 64'd42, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #3;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
